// File: rtl/tmboc_corr_acc_pkg.sv
// tmboc_corr_acc shared types: default widths, FSM encoding and code wipe-off helper.
// Optional power output is built when TMBOC_CORR_PWR_EN is defined.
package tmboc_corr_pkg;

  localparam int SAMP_WIDTH    = 4;
  localparam int PRN_PHS_WIDTH = 15;
  localparam int ACC_WIDTH     = 20;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Sign-extend the low w bits of v to 64 bits, then negate when neg=1.
  function automatic logic [63:0] sext_neg(
    input logic [63:0] v,
    input int unsigned w,
    input logic        neg
  );
    logic [63:0] m;
    logic [63:0] r;
    logic        sb;
    m  = ~64'd0 << w;
    sb = |(v & (64'd1 << (w - 1)));
    r  = sb ? (v | m) : (v & ~m);
    return neg ? (~r + 64'd1) : r;
  endfunction

endpackage

// File: rtl/tmboc_corr_acc_if.sv
// Sample stream from the code generator and I/Q dump handshake to the search logic.
// tx_corr_pwr exists only when TMBOC_CORR_PWR_EN is defined.
interface tmboc_samp_if #(
  parameter int SW = tmboc_corr_pkg::SAMP_WIDTH,
  parameter int PW = tmboc_corr_pkg::PRN_PHS_WIDTH
);
  logic [SW-1:0] rx_samp_i;
  logic [SW-1:0] rx_samp_q;
  logic          rx_samp_vld;
  logic          rx_loc_code;
  logic          rx_prn_sop;
  logic          rx_prn_eop;
  logic [PW-2:0] rx_prn_phs;

  modport master (
    output rx_samp_i, rx_samp_q, rx_samp_vld,
    output rx_loc_code, rx_prn_sop, rx_prn_eop, rx_prn_phs
  );
  modport slave (
    input rx_samp_i, rx_samp_q, rx_samp_vld,
    input rx_loc_code, rx_prn_sop, rx_prn_eop, rx_prn_phs
  );
endinterface

interface tmboc_dump_if #(
  parameter int AW = tmboc_corr_pkg::ACC_WIDTH,
  parameter int PW = tmboc_corr_pkg::PRN_PHS_WIDTH
);
  logic [AW-1:0]   tx_corr_i;
  logic [AW-1:0]   tx_corr_q;
  logic [PW-1:0]   tx_corr_cnt;
  logic [PW-2:0]   tx_corr_phs;
  logic            tx_corr_vld;
  logic            rx_corr_rdy;
  logic            tx_ovf;
  logic            tx_frm_err;
`ifdef TMBOC_CORR_PWR_EN
  logic [2*AW-1:0] tx_corr_pwr;
`endif

  modport master (
    output tx_corr_i, tx_corr_q, tx_corr_cnt, tx_corr_phs,
`ifdef TMBOC_CORR_PWR_EN
    output tx_corr_pwr,
`endif
    output tx_corr_vld, tx_ovf, tx_frm_err,
    input  rx_corr_rdy
  );
  modport slave (
    input  tx_corr_i, tx_corr_q, tx_corr_cnt, tx_corr_phs,
`ifdef TMBOC_CORR_PWR_EN
    input  tx_corr_pwr,
`endif
    input  tx_corr_vld, tx_ovf, tx_frm_err,
    output rx_corr_rdy
  );
endinterface

// File: rtl/tmboc_corr_acc_wipeoff.sv
// Code wipe-off: code 0 passes the sample, code 1 negates it,
// result sign-extended to the accumulator width.
module tmboc_code_wipeoff
  import tmboc_corr_pkg::*;
#(
  parameter int SW = SAMP_WIDTH,
  parameter int AW = ACC_WIDTH
) (
  input  logic [SW-1:0] samp,
  input  logic          code,
  output logic [AW-1:0] prod
);

  always_comb begin
    prod = AW'(sext_neg(64'(samp), SW, code));
  end

endmodule

// File: rtl/tmboc_corr_acc.sv
// Coherent I/Q integrator over one PRN period with a one-deep dump register.
// TMBOC_CORR_PWR_EN adds a pipelined I^2+Q^2 output (dump latency 2).
module tmboc_corr_acc #(
  parameter int SAMP_WIDTH    = tmboc_corr_pkg::SAMP_WIDTH,
  parameter int PRN_PHS_WIDTH = tmboc_corr_pkg::PRN_PHS_WIDTH,
  parameter int ACC_WIDTH     = tmboc_corr_pkg::ACC_WIDTH
) (
  input  logic          rx_clk,
  input  logic          rx_rst,
  tmboc_samp_if.slave   rx,
  tmboc_dump_if.master  tx
);
  import tmboc_corr_pkg::*;

  localparam int AW = ACC_WIDTH;
  localparam int PW = PRN_PHS_WIDTH;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_i_q, acc_i_d;
  logic [AW-1:0] acc_q_q, acc_q_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          frm_err_q, frm_err_d;

  logic [AW-1:0] prod_i, prod_q;
  logic [AW-1:0] sum_i, sum_q;
  logic [PW-1:0] cnt_sum;
  logic          dump_go;
  logic          take;

  tmboc_code_wipeoff #(.SW(SAMP_WIDTH), .AW(AW)) u_wipe_i (
    .samp (rx.rx_samp_i),
    .code (rx.rx_loc_code),
    .prod (prod_i)
  );

  tmboc_code_wipeoff #(.SW(SAMP_WIDTH), .AW(AW)) u_wipe_q (
    .samp (rx.rx_samp_q),
    .code (rx.rx_loc_code),
    .prod (prod_q)
  );

  // sop always restarts the sum, so a sop+eop sample dumps just itself
  always_comb begin
    state_d   = state_q;
    acc_i_d   = acc_i_q;
    acc_q_d   = acc_q_q;
    cnt_d     = cnt_q;
    frm_err_d = frm_err_q;
    dump_go   = 1'b0;
    sum_i   = (rx.rx_prn_sop ? '0 : acc_i_q) + prod_i;
    sum_q   = (rx.rx_prn_sop ? '0 : acc_q_q) + prod_q;
    cnt_sum = (rx.rx_prn_sop ? '0 : cnt_q) + PW'(1);
    take    = rx.rx_samp_vld &
              ((state_q == ACCUM) | rx.rx_prn_sop);
    if (take) begin
      if (state_q == ACCUM && rx.rx_prn_sop) begin
        frm_err_d = 1'b1;
      end
      if (rx.rx_prn_eop) begin
        dump_go = 1'b1;
        state_d = IDLE;
        acc_i_d = '0;
        acc_q_d = '0;
        cnt_d   = '0;
      end else begin
        state_d = ACCUM;
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        cnt_d   = cnt_sum;
      end
    end
  end

  logic          nd_go;
  logic [AW-1:0] nd_i, nd_q;
  logic [PW-1:0] nd_cnt;
  logic [PW-2:0] nd_phs;

`ifdef TMBOC_CORR_PWR_EN
  logic            pv_q;
  logic [AW-1:0]   pi_q, pq_q;
  logic [PW-1:0]   pc_q;
  logic [PW-2:0]   pp_q;
  logic [2*AW-1:0] ei, eq, nd_pwr;
  logic [2*AW-1:0] pwr_q, pwr_d;

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      pv_q <= 1'b0;
      pi_q <= '0;
      pq_q <= '0;
      pc_q <= '0;
      pp_q <= '0;
    end else begin
      pv_q <= dump_go;
      pi_q <= sum_i;
      pq_q <= sum_q;
      pc_q <= cnt_sum;
      pp_q <= rx.rx_prn_phs;
    end
  end

  always_comb begin
    nd_go  = pv_q;
    nd_i   = pi_q;
    nd_q   = pq_q;
    nd_cnt = pc_q;
    nd_phs = pp_q;
    ei     = {{AW{pi_q[AW-1]}}, pi_q};
    eq     = {{AW{pq_q[AW-1]}}, pq_q};
    nd_pwr = ei * ei + eq * eq;
  end
`else
  always_comb begin
    nd_go  = dump_go;
    nd_i   = sum_i;
    nd_q   = sum_q;
    nd_cnt = cnt_sum;
    nd_phs = rx.rx_prn_phs;
  end
`endif

  logic          vld_q, vld_d;
  logic          ovf_q, ovf_d;
  logic          load;
  logic [AW-1:0] out_i_q, out_i_d;
  logic [AW-1:0] out_q_q, out_q_d;
  logic [PW-1:0] out_c_q, out_c_d;
  logic [PW-2:0] out_p_q, out_p_d;

  // a held dump that is not taken this cycle blocks the new one
  always_comb begin
    load    = nd_go & (~vld_q | tx.rx_corr_rdy);
    vld_d   = load | (vld_q & ~tx.rx_corr_rdy);
    ovf_d   = ovf_q | (nd_go & vld_q & ~tx.rx_corr_rdy);
    out_i_d = load ? nd_i   : out_i_q;
    out_q_d = load ? nd_q   : out_q_q;
    out_c_d = load ? nd_cnt : out_c_q;
    out_p_d = load ? nd_phs : out_p_q;
`ifdef TMBOC_CORR_PWR_EN
    pwr_d   = load ? nd_pwr : pwr_q;
`endif
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q   <= IDLE;
      acc_i_q   <= '0;
      acc_q_q   <= '0;
      cnt_q     <= '0;
      frm_err_q <= 1'b0;
      vld_q     <= 1'b0;
      ovf_q     <= 1'b0;
      out_i_q   <= '0;
      out_q_q   <= '0;
      out_c_q   <= '0;
      out_p_q   <= '0;
`ifdef TMBOC_CORR_PWR_EN
      pwr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_i_q   <= acc_i_d;
      acc_q_q   <= acc_q_d;
      cnt_q     <= cnt_d;
      frm_err_q <= frm_err_d;
      vld_q     <= vld_d;
      ovf_q     <= ovf_d;
      out_i_q   <= out_i_d;
      out_q_q   <= out_q_d;
      out_c_q   <= out_c_d;
      out_p_q   <= out_p_d;
`ifdef TMBOC_CORR_PWR_EN
      pwr_q     <= pwr_d;
`endif
    end
  end

  assign tx.tx_corr_i   = out_i_q;
  assign tx.tx_corr_q   = out_q_q;
  assign tx.tx_corr_cnt = out_c_q;
  assign tx.tx_corr_phs = out_p_q;
  assign tx.tx_corr_vld = vld_q;
  assign tx.tx_ovf      = ovf_q;
  assign tx.tx_frm_err  = frm_err_q;
`ifdef TMBOC_CORR_PWR_EN
  assign tx.tx_corr_pwr = pwr_q;
`endif

endmodule

// File: tb/tb_tmboc_corr_acc.sv
// Directed bench for tmboc_corr_acc; PWR checks build when TMBOC_CORR_PWR_EN is defined.
module tb_tmboc_corr_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  tmboc_samp_if rx_if ();
  tmboc_dump_if tx_if ();

  tmboc_corr_acc dut (
    .rx_clk (clk),
    .rx_rst (rst),
    .rx     (rx_if.slave),
    .tx     (tx_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic samp(input int si, input int sq, input logic code,
                      input logic sop, input logic eop, input int phs);
    rx_if.rx_samp_i   = 4'(si);
    rx_if.rx_samp_q   = 4'(sq);
    rx_if.rx_loc_code = code;
    rx_if.rx_prn_sop  = sop;
    rx_if.rx_prn_eop  = eop;
    rx_if.rx_prn_phs  = 14'(phs);
    rx_if.rx_samp_vld = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_vld();
    rx_if.rx_samp_vld = 1'b0;
    rx_if.rx_prn_sop  = 1'b0;
    rx_if.rx_prn_eop  = 1'b0;
  endtask

  task automatic idle();
    drop_vld();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dump();
    drop_vld();
`ifdef TMBOC_CORR_PWR_EN
    chk("pwr_lat_vld", 64'(tx_if.tx_corr_vld), 0);
    @(posedge clk);
    #1;
`endif
  endtask

  function automatic logic signed [63:0] si(input logic [19:0] v);
    return 64'($signed(v));
  endfunction

  initial begin
    rx_if.rx_samp_i   = '0;
    rx_if.rx_samp_q   = '0;
    rx_if.rx_samp_vld = 1'b0;
    rx_if.rx_loc_code = 1'b0;
    rx_if.rx_prn_sop  = 1'b0;
    rx_if.rx_prn_eop  = 1'b0;
    rx_if.rx_prn_phs  = '0;
    tx_if.rx_corr_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 64'(tx_if.tx_corr_vld), 0);
    chk("rst_i", si(tx_if.tx_corr_i), 0);
    chk("rst_cnt", 64'(tx_if.tx_corr_cnt), 0);
    chk("rst_phs", 64'(tx_if.tx_corr_phs), 0);
    chk("rst_ovf", 64'(tx_if.tx_ovf), 0);
    chk("rst_frm", 64'(tx_if.tx_frm_err), 0);
    rst = 1'b0;
    idle();

    // full period, code all zero
    for (int k = 0; k < 4091; k++) samp(3, -2, 1'b0, k == 0, 1'b0, k);
    chk("p0_pre_vld", 64'(tx_if.tx_corr_vld), 0);
    samp(3, -2, 1'b0, 1'b0, 1'b1, 4091);
    wait_dump();
    chk("p0_vld", 64'(tx_if.tx_corr_vld), 1);
    chk("p0_i", si(tx_if.tx_corr_i), 12276);
    chk("p0_q", si(tx_if.tx_corr_q), -8184);
    chk("p0_cnt", 64'(tx_if.tx_corr_cnt), 4092);
    chk("p0_phs", 64'(tx_if.tx_corr_phs), 4091);
`ifdef TMBOC_CORR_PWR_EN
    chk("p0_pwr", 64'(tx_if.tx_corr_pwr), 217678032);
`endif
    idle();
    chk("p0_vld_drop", 64'(tx_if.tx_corr_vld), 0);

    // alternating code cancels
    for (int k = 0; k < 4092; k++)
      samp(3, -2, k[0], k == 0, k == 4091, k);
    wait_dump();
    chk("p1_vld", 64'(tx_if.tx_corr_vld), 1);
    chk("p1_i", si(tx_if.tx_corr_i), 0);
    chk("p1_q", si(tx_if.tx_corr_q), 0);
    chk("p1_cnt", 64'(tx_if.tx_corr_cnt), 4092);
`ifdef TMBOC_CORR_PWR_EN
    chk("p1_pwr", 64'(tx_if.tx_corr_pwr), 0);
`endif
    idle();

    // overflow while held
    tx_if.rx_corr_rdy = 1'b0;
    samp(1, 2, 1'b0, 1'b1, 1'b0, 6);
    samp(1, 2, 1'b0, 1'b0, 1'b1, 7);
    wait_dump();
    chk("ov_first_vld", 64'(tx_if.tx_corr_vld), 1);
    chk("ov_pre_ovf", 64'(tx_if.tx_ovf), 0);
    samp(5, 5, 1'b0, 1'b1, 1'b1, 9);
    wait_dump();
    idle();
    chk("ov_ovf", 64'(tx_if.tx_ovf), 1);
    chk("ov_hold_vld", 64'(tx_if.tx_corr_vld), 1);
    chk("ov_hold_i", si(tx_if.tx_corr_i), 2);
    chk("ov_hold_q", si(tx_if.tx_corr_q), 4);
    chk("ov_hold_cnt", 64'(tx_if.tx_corr_cnt), 2);
    chk("ov_hold_phs", 64'(tx_if.tx_corr_phs), 7);
    tx_if.rx_corr_rdy = 1'b1;
    idle();
    chk("ov_xfer_vld", 64'(tx_if.tx_corr_vld), 0);
    chk("ov_sticky", 64'(tx_if.tx_ovf), 1);

    // sop mid-period
    for (int k = 0; k < 50; k++) samp(1, -1, 1'b0, k == 0, 1'b0, k);
    chk("fe_pre", 64'(tx_if.tx_frm_err), 0);
    samp(1, -1, 1'b0, 1'b1, 1'b0, 50);
    chk("fe_set", 64'(tx_if.tx_frm_err), 1);
    for (int k = 51; k < 60; k++) samp(1, -1, 1'b0, 1'b0, 1'b0, k);
    samp(1, -1, 1'b0, 1'b0, 1'b1, 60);
    wait_dump();
    chk("fe_cnt", 64'(tx_if.tx_corr_cnt), 11);
    chk("fe_i", si(tx_if.tx_corr_i), 11);
    chk("fe_q", si(tx_if.tx_corr_q), -11);
    chk("fe_phs", 64'(tx_if.tx_corr_phs), 60);
    idle();

    // sop+eop in IDLE, code 1, most negative sample
    samp(-8, 7, 1'b1, 1'b1, 1'b1, 3);
    wait_dump();
    chk("se_vld", 64'(tx_if.tx_corr_vld), 1);
    chk("se_cnt", 64'(tx_if.tx_corr_cnt), 1);
    chk("se_i", si(tx_if.tx_corr_i), 8);
    chk("se_q", si(tx_if.tx_corr_q), -7);
    chk("se_frm_sticky", 64'(tx_if.tx_frm_err), 1);
    idle();

    // reset mid-integration
    for (int k = 0; k < 100; k++) samp(1, 1, 1'b0, k == 0, 1'b0, k);
    rst = 1'b1;
    #1;
    chk("ra_i", si(tx_if.tx_corr_i), 0);
    chk("ra_cnt", 64'(tx_if.tx_corr_cnt), 0);
    chk("ra_vld", 64'(tx_if.tx_corr_vld), 0);
    chk("ra_ovf", 64'(tx_if.tx_ovf), 0);
    chk("ra_frm", 64'(tx_if.tx_frm_err), 0);
    drop_vld();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rx_if.rx_prn_sop = 1'b1;
    rx_if.rx_prn_eop = 1'b1;
    @(posedge clk);
    #1;
    idle();
    chk("nq_vld", 64'(tx_if.tx_corr_vld), 0);
    samp(2, 3, 1'b0, 1'b1, 1'b0, 0);
    rx_if.rx_samp_vld = 1'b0;
    rx_if.rx_prn_sop  = 1'b0;
    rx_if.rx_prn_eop  = 1'b1;
    @(posedge clk);
    #1;
    samp(2, 3, 1'b0, 1'b0, 1'b1, 1);
    wait_dump();
    chk("rr_vld", 64'(tx_if.tx_corr_vld), 1);
    chk("rr_cnt", 64'(tx_if.tx_corr_cnt), 2);
    chk("rr_i", si(tx_if.tx_corr_i), 4);
    chk("rr_q", si(tx_if.tx_corr_q), 6);
    chk("rr_frm", 64'(tx_if.tx_frm_err), 0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tmboc_corr_acc.md
Name: tmboc_corr_acc

Overview:
- Consumer end of the local TMBOC/PRN code stream from the acquisition code generator.
- Wipes the local code bit off received I/Q samples and integrates over one PRN period, framed by the generator's sop/eop pulses.
- Emits one coherent I/Q dump per period over a valid/ready handshake to the acquisition search logic.

Parameters:
SAMP_WIDTH, 4, signed width of each received I and Q sample
PRN_PHS_WIDTH, 15, width of the code-phase tag from the generator
ACC_WIDTH, 20, signed accumulator/dump width (>= SAMP_WIDTH + 13 for a 4092-chip period without overflow)

Ports:
rx_clk  input  1  sole clock
rx_rst  input  1  reset, asynchronous, active-high
rx_samp_i  input  SAMP_WIDTH  signed received in-phase sample
rx_samp_q  input  SAMP_WIDTH  signed received quadrature sample
rx_samp_vld  input  1  sample strobe; qualifies all other rx_ stream inputs
rx_loc_code  input  1  local code bit (tmboc or prn) aligned with the sample
rx_prn_sop  input  1  first chip of period
rx_prn_eop  input  1  last chip of period
rx_prn_phs  input  PRN_PHS_WIDTH-1  generator code phase
tx_corr_i  output  ACC_WIDTH  I dump
tx_corr_q  output  ACC_WIDTH  Q dump
tx_corr_cnt  output  PRN_PHS_WIDTH  samples integrated in this dump
tx_corr_phs  output  PRN_PHS_WIDTH-1  rx_prn_phs captured at eop
tx_corr_vld  output  1  dump valid
rx_corr_rdy  input  1  downstream accepts dump
tx_ovf  output  1  sticky: dump dropped while output still held
tx_frm_err  output  1  sticky: sop seen mid-period

Behaviour:
- Reset (async assert, sync release): all outputs 0; accumulators and counter 0; state IDLE.
- Wipe-off: code 0 -> +sample; code 1 -> -sample. Sign-extend to ACC_WIDTH before add. Two's-complement wrap, no saturation.
- rx_prn_sop, rx_prn_eop, rx_prn_phs and rx_loc_code are ignored unless rx_samp_vld=1.
- IDLE: wait for qualified sop. On sop: acc <= product, cnt <= 1, go ACCUM. If eop is also set, dump immediately and stay IDLE.
- ACCUM: each qualified sample: acc <= acc + product, cnt <= cnt + 1.
- ACCUM, qualified sop: discard partial sum, restart with product, cnt <= 1, set tx_frm_err.
- ACCUM, qualified eop: dump = acc + product, cnt+1, phs captured; go IDLE. If sop and eop arrive together, treat as a restart followed by an immediate one-sample dump.
- Latency: tx_corr_vld rises the cycle after the sampled eop edge.
- Output register is one deep. It holds while tx_corr_vld=1 and rx_corr_rdy=0. Transfer occurs when vld=1 and rdy=1; vld clears next cycle unless a new dump loads in the same cycle.
- Dump when the output is full and not accepted that cycle: new dump is dropped, the held dump is unchanged, tx_ovf is set. Acceptance and a new load in the same cycle is legal: the new dump loads and vld stays 1.
- Sticky flags clear only on reset.
- Counter wraps at 2^PRN_PHS_WIDTH; no flag.

Optional Feature:
- Macro TMBOC_CORR_PWR_EN.
- Defined: adds output tx_corr_pwr, width 2*ACC_WIDTH, = I^2 + Q^2 of the dump. One extra pipeline register is inserted, so all dump outputs and tx_corr_vld appear 2 cycles after eop. Handshake rules are unchanged.
- Undefined: port absent, latency 1.

Decomposition:
- Package tmboc_corr_pkg: SAMP_WIDTH/ACC_WIDTH/PRN_PHS_WIDTH defaults, the IDLE/ACCUM state encoding, and the sign-extend/negate function.
- One sub-module, tmboc_code_wipeoff: combinational sign flip plus sign extension, instantiated for I and Q.

Test Plan:
- Reset mid-ACCUM after 100 samples -> all outputs 0 immediately, state IDLE; next sop starts a fresh integration with cnt=1.
- 4092-sample period, I=+3, Q=-2, all code 0, rdy=1 -> I=12276, Q=-8184, cnt=4092, vld pulses 1 cycle after eop.
- Same stimulus with code alternating 0/1 -> I=0, Q=0, cnt=4092.
- Second dump arrives while rdy=0 -> first dump still held, tx_ovf=1; after rdy rises, first dump transfers and vld drops.
- sop at sample 50 of an active period, then eop at sample 10 after it -> tx_frm_err=1, cnt=11; sop+eop on the same sample in IDLE -> cnt=1, I=±sample.
- TMBOC_CORR_PWR_EN defined, I=12276, Q=-8184 -> tx_corr_pwr=217678032, vld 2 cycles after eop.
